mem_scheduler: RTL

MEM_SCHEDULER -- requirements
Module: mem_scheduler

---
 rtl/mem_scheduler_pkg.sv | 23 ++
 rtl/mem_scheduler_rr_pick.sv | 36 +++
 rtl/mem_scheduler.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/mem_scheduler_pkg.sv
// Shared definitions for the three-requester memory scheduler: FSM states,
// requester indices and wait-counter sizing.
package mem_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } mem_sched_state_t;

    localparam int REQ_DCACHE = 0;
    localparam int REQ_ICACHE = 1;
    localparam int REQ_DMA    = 2;

    localparam int         WAIT_CNT_W   = 8;
    localparam logic [7:0] WAIT_CNT_MAX = 8'hFF;

    // Index width that stays legal for a single requester.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_scheduler_rr_pick.sv
// Combinational rotating-priority pick: first set bit of mask_i at or after
// start_i, wrapping modulo N.
module rr_pick
    import mem_scheduler_pkg::*;
#(
    parameter int N     = 3,
    parameter int IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     mask_i,
    input  logic [IDX_W-1:0] start_i,
    output logic             any_o,
    output logic [IDX_W-1:0] idx_o
);

    int off;
    int best;

    always_comb begin
        any_o = 1'b0;
        idx_o = '0;
        best  = N;
        off   = 0;
        for (int i = 0; i < N; i++) begin
            off = i - int'(start_i);
            if (off < 0) begin
                off = off + N;
            end
            if (mask_i[i] && (off < best)) begin
                best  = off;
                idx_o = IDX_W'(i);
                any_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_scheduler.sv
// Single-outstanding memory scheduler for dcache, icache and a DMA port,
// with round-robin arbitration and a starvation override.
//
// state | meaning
// IDLE  | no transaction; pick and latch a winner when any request is valid
// ISSUE | mem_valid_o high with latched command; wait for mem_ready_i
// WAIT  | command accepted; wait for mem_done_i, then respond to the owner
module mem_scheduler
    import mem_scheduler_pkg::*;
#(
    parameter int NUM_REQ         = 3,
    parameter int ADDR_SIZE       = 32,
    parameter int CACHE_LINE_SIZE = 256,
    parameter int MAX_WAIT        = 15
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic [NUM_REQ-1:0]             req_valid_i,
    input  logic [NUM_REQ-1:0]             req_write_i,
    input  logic [NUM_REQ*ADDR_SIZE-1:0]   req_addr_i,
    input  logic [NUM_REQ*CACHE_LINE_SIZE-1:0] req_wdata_i,
    output logic [NUM_REQ-1:0]             req_ready_o,
    output logic [NUM_REQ-1:0]             resp_valid_o,
    output logic [CACHE_LINE_SIZE-1:0]     resp_rdata_o,
    output logic                           mem_valid_o,
    output logic                           mem_write_o,
    output logic [ADDR_SIZE-1:0]           mem_addr_o,
    output logic [CACHE_LINE_SIZE-1:0]     mem_wdata_o,
    input  logic                           mem_ready_i,
    input  logic                           mem_done_i,
    input  logic [CACHE_LINE_SIZE-1:0]     mem_rdata_i
);

    localparam int IDX_W = idx_width(NUM_REQ);
    typedef logic [IDX_W-1:0] idx_t;

    mem_sched_state_t           state_q;
    idx_t                       owner_q;
    idx_t                       last_q;
    logic                       write_q;
    logic [ADDR_SIZE-1:0]       addr_q;
    logic [CACHE_LINE_SIZE-1:0] wdata_q;
    logic [CACHE_LINE_SIZE-1:0] resp_rdata_q;
    logic [NUM_REQ-1:0]         resp_valid_q;
    logic [WAIT_CNT_W-1:0]      wait_cnt_q [NUM_REQ];
    logic [WAIT_CNT_W-1:0]      wait_cnt_d [NUM_REQ];

    idx_t               rr_start;
    idx_t               starve_idx;
    idx_t               rr_idx;
    idx_t               win_idx;
    logic               starve_any;
    logic               rr_any;
    logic               grant;
    logic [NUM_REQ-1:0] starve_mask;
    logic [NUM_REQ-1:0] ready_d;

    assign rr_start = (last_q == idx_t'(NUM_REQ - 1)) ? '0 : idx_t'(last_q + 1'b1);

    always_comb begin
        starve_mask = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            starve_mask[i] = req_valid_i[i] && (wait_cnt_q[i] >= WAIT_CNT_W'(MAX_WAIT));
        end
    end

    rr_pick #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pick_starved (
        .mask_i  (starve_mask),
        .start_i ('0),
        .any_o   (starve_any),
        .idx_o   (starve_idx)
    );

    rr_pick #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pick_rr (
        .mask_i  (req_valid_i),
        .start_i (rr_start),
        .any_o   (rr_any),
        .idx_o   (rr_idx)
    );

    assign win_idx = starve_any ? starve_idx : rr_idx;

    // A grant is held off during the response cycle so owner and new winner never overlap.
    assign grant = reset_i && (state_q == IDLE) && (resp_valid_q == '0) && rr_any;

    always_comb begin
        ready_d = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            ready_d[i] = grant && (win_idx == idx_t'(i));
        end
    end

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!req_valid_i[i] || ready_d[i]) begin
                wait_cnt_d[i] = '0;
            end else if (wait_cnt_q[i] != WAIT_CNT_MAX) begin
                wait_cnt_d[i] = wait_cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            last_q       <= idx_t'(NUM_REQ - 1);
            write_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            resp_rdata_q <= '0;
            resp_valid_q <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                wait_cnt_q[i] <= '0;
            end
        end else begin
            resp_valid_q <= '0;
            wait_cnt_q   <= wait_cnt_d;
            case (state_q)
                IDLE: begin
                    if (grant) begin
                        owner_q <= win_idx;
                        write_q <= req_write_i[win_idx];
                        addr_q  <= req_addr_i[win_idx*ADDR_SIZE +: ADDR_SIZE];
                        wdata_q <= req_wdata_i[win_idx*CACHE_LINE_SIZE +: CACHE_LINE_SIZE];
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mem_ready_i) begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_done_i) begin
                        resp_valid_q[owner_q] <= 1'b1;
                        resp_rdata_q          <= mem_rdata_i;
                        last_q                <= owner_q;
                        state_q               <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready_o  = ready_d;
    assign resp_valid_o = resp_valid_q;
    assign resp_rdata_o = resp_rdata_q;
    assign mem_valid_o  = (state_q == ISSUE);
    assign mem_write_o  = write_q;
    assign mem_addr_o   = addr_q;
    assign mem_wdata_o  = wdata_q;

endmodule
